spike_event_readout_arbiter: RTL and testbench
==============================================

// Module: spike_event_readout_arbiter
// PURPOSE
//  Shares the narrow output path among the NUM_UNITS spike-detection units of processing_system.
//  Latches each unit's spike/event, arbitrates round-robin, and queues {unit_id,event} words in a FIFO.
//  The FIFO drains through a valid/ready handshake to the pad/readout logic.
//  Replaces static per-unit output muxing, so no spike is lost while another unit is being read.
// PARAMETERS
//  NUM_UNITS   2   number of detection units (>=2)
//  EVT_WIDTH   2   event code bits per unit
//  FIFO_DEPTH  4   output queue entries (power of 2, >=2)
//  ID_WIDTH    derived localparam = max(1,$clog2(NUM_UNITS)); not overridable
// PORTS
//  clk           in   1                    system clock, rising edge
//  rst           in   1                    async, active-high reset
//  spike_in      in   NUM_UNITS            per-unit spike strobe, 1 cycle per spike
//  event_in      in   EVT_WIDTH*NUM_UNITS  per-unit event code; unit i = [i*EVT_WIDTH +: EVT_WIDTH]; valid with spike_in[i]
//  unit_mask     in   NUM_UNITS            1 = unit enabled for readout
//  out_ready     in   1                    consumer accepts the head word
//  out_valid     out  1                    FIFO not empty
//  out_unit      out  ID_WIDTH             unit index of the head word
//  out_event     out  EVT_WIDTH            event code of the head word
//  fifo_level    out  $clog2(FIFO_DEPTH)+1 current FIFO occupancy
//  overflow      out  1                    sticky: at least one spike was dropped
//  overflow_clr  in   1                    clears overflow
// BEHAVIOUR
//  Reset (async assert, sync deassert, external): pending=0, FIFO empty, out_valid=0, out_unit=0,
//   out_event=0, fifo_level=0, overflow=0, RR pointer gives unit 0 top priority. Outputs drop immediately.
//  Capture, per unit i, each edge:
//   - unit_mask[i]=0: pending[i] cleared, spike ignored, no overflow.
//   - spike_in[i]=1 and (pending[i]=0 or unit i granted this cycle): pending[i]<=1, code[i]<=event code.
//   - spike_in[i]=1 and pending[i]=1 and not granted: spike dropped, code[i] unchanged, overflow<=1.
//  Arbitration: one grant per cycle, only when fifo_level<FIFO_DEPTH (registered level; a same-cycle pop
//   does not enable a push). Candidates are pending & unit_mask. Search starts at last_grant+1 mod NUM_UNITS.
//   Granted unit: push {i,code[i]}, clear pending[i] (unless re-captured), last_grant<=i.
//  Latency: spike edge at cycle t -> pending at t+1 -> pushed at end of t+1 -> out_valid=1 in t+2.
//  FIFO: out_unit/out_event come from the head register/RAM read (no bubble).
//   Pop on out_valid&out_ready. Push+pop in one cycle: level unchanged.
//   Pop when empty: no-op. Pointers wrap mod FIFO_DEPTH.
//  out_unit/out_event are held stable while out_valid=1 and out_ready=0. They are don't-care when out_valid=0.
//  overflow: set has priority over overflow_clr in the same cycle. Otherwise overflow_clr clears it.
//  Fairness: with every unit continuously pending, each unit is granted once per NUM_UNITS grants.
// TESTING
//  1 Reset; spike_in=2'b10, event_in=4'b1000 for 1 cycle, out_ready=1, mask=11 -> 2 cycles later
//    out_valid=1, out_unit=1, out_event=2'b10 for 1 cycle; fifo_level returns to 0.
//  2 Both spike in same cycle (codes 01,11) -> out words (0,01) then (1,11) on consecutive cycles. Repeat
//    with unit0 spiking every cycle and unit1 once -> unit1 word appears within 2 grants.
//  3 out_ready=0, alternating spikes -> fifo_level saturates at 4, one pending per unit held. Further spike on
//    unit0 -> overflow=1. Then out_ready=1 -> 6 words drain in order, with no duplicates.
//  4 unit_mask=2'b01, spikes on unit1 -> no output, overflow stays 0. Clear mask bit while pending -> word discarded.
//  5 fifo_level=3, assert rst mid-cycle -> out_valid=0 and fifo_level=0 before the next clk edge.
//    After release, the next spike works normally.
//  6 overflow_clr=1 in the same cycle as a new drop -> overflow stays 1. overflow_clr alone -> 0 next cycle.

Source files
------------

// File: rtl/spike_event_readout_arbiter.sv
// Round-robin readout arbiter: latches per-unit spike events and queues {unit,event}
// words in a small FIFO that drains over a valid/ready handshake.
module spike_event_readout_arbiter #(
  parameter int NUM_UNITS  = 2,
  parameter int EVT_WIDTH  = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_WIDTH  = ($clog2(NUM_UNITS) > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_UNITS-1:0]           spike_in,
  input  logic [EVT_WIDTH*NUM_UNITS-1:0] event_in,
  input  logic [NUM_UNITS-1:0]           unit_mask,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [ID_WIDTH-1:0]            out_unit,
  output logic [EVT_WIDTH-1:0]           out_event,
  output logic [LVL_WIDTH-1:0]           fifo_level,
  output logic                           overflow,
  input  logic                           overflow_clr
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

  logic [NUM_UNITS-1:0]          pending;
  logic [NUM_UNITS-1:0]          candidates;
  logic [NUM_UNITS-1:0]          granted;
  logic [NUM_UNITS-1:0]          drop;
  logic [EVT_WIDTH-1:0]          code [NUM_UNITS];
  logic [ID_WIDTH-1:0]           last_grant;
  logic [ID_WIDTH-1:0]           grant_idx;
  logic                          grant_valid;
  logic [ID_WIDTH+EVT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]          rd_ptr;
  logic [PTR_WIDTH-1:0]          wr_ptr;
  logic [LVL_WIDTH-1:0]          level;
  logic                          push;
  logic                          pop;

  assign candidates = pending & unit_mask;

  // Search starts one past the previous winner; only the registered level gates a push.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (level < LVL_WIDTH'(FIFO_DEPTH)) begin
      for (int k = 1; k <= NUM_UNITS; k++) begin
        idx = (int'(last_grant) + k) % NUM_UNITS;
        if (!grant_valid && candidates[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_WIDTH'(idx);
        end
      end
    end
  end

  always_comb begin
    granted = '0;
    drop    = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      granted[i] = grant_valid && (grant_idx == ID_WIDTH'(i));
      drop[i]    = unit_mask[i] & spike_in[i] & pending[i] & ~granted[i];
    end
  end

  // A unit being granted this cycle frees its slot, so a same-cycle spike is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      last_grant <= ID_WIDTH'(NUM_UNITS - 1);
      for (int i = 0; i < NUM_UNITS; i++) code[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (!unit_mask[i]) begin
          pending[i] <= 1'b0;
        end else if (spike_in[i] && (!pending[i] || granted[i])) begin
          pending[i] <= 1'b1;
          code[i]    <= event_in[i*EVT_WIDTH +: EVT_WIDTH];
        end else if (granted[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_valid) last_grant <= grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overflow <= 1'b0;
    else if (|drop)         overflow <= 1'b1;
    else if (overflow_clr)  overflow <= 1'b0;
  end

  assign push = grant_valid;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem[j] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {grant_idx, code[grant_idx]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign out_valid             = (level != '0);
  assign {out_unit, out_event} = mem[rd_ptr];
  assign fifo_level            = level;

endmodule

// File: tb/tb_spike_event_readout_arbiter.sv
// Bench for spike_event_readout_arbiter: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model of the readout path.
module tb_spike_event_readout_arbiter;

  localparam int NU = 2;
  localparam int EW = 2;
  localparam int FD = 4;
  localparam int IW = 1;
  localparam int LW = 3;

  logic             clk;
  logic             rst;
  logic [NU-1:0]    spike_in;
  logic [EW*NU-1:0] event_in;
  logic [NU-1:0]    unit_mask;
  logic             out_ready;
  logic             out_valid;
  logic [IW-1:0]    out_unit;
  logic [EW-1:0]    out_event;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic             overflow_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            unit;
    logic [EW-1:0] evt;
  } word_t;

  word_t         q[$];
  bit            m_pending [NU];
  logic [EW-1:0] m_code [NU];
  int            m_last;
  bit            m_ovf;

  spike_event_readout_arbiter #(.NUM_UNITS(NU), .EVT_WIDTH(EW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (spike_in),
    .event_in     (event_in),
    .unit_mask    (unit_mask),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_unit     (out_unit),
    .out_event    (out_event),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NU; i++) begin
      m_pending[i] = 1'b0;
      m_code[i]    = '0;
    end
    m_last = NU - 1;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the readout path, evaluated from the pre-edge state and inputs.
  task automatic model_update();
    int  g;
    bit  dropped;
    g       = -1;
    dropped = 1'b0;
    if (q.size() < FD) begin
      for (int k = 1; k <= NU; k++) begin
        int idx;
        idx = (m_last + k) % NU;
        if (g < 0 && m_pending[idx] && unit_mask[idx]) g = idx;
      end
    end
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{unit: g, evt: m_code[g]});
      m_last = g;
    end
    for (int i = 0; i < NU; i++) begin
      if (!unit_mask[i]) m_pending[i] = 1'b0;
      else if (spike_in[i] && (!m_pending[i] || g == i)) begin
        m_pending[i] = 1'b1;
        m_code[i]    = event_in[i*EW +: EW];
      end else if (spike_in[i]) dropped = 1'b1;
      else if (g == i) m_pending[i] = 1'b0;
    end
    if (dropped) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NU-1:0] spk, input logic [EW*NU-1:0] evt,
                               input logic rdy, input logic [NU-1:0] msk, input logic clr);
    spike_in     = spk;
    event_in     = evt;
    out_ready    = rdy;
    unit_mask    = msk;
    overflow_clr = clr;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
    checkValue({tag, ".level"}, 32'(fifo_level), 32'(q.size()));
    checkValue({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) begin
      checkValue({tag, ".unit"}, 32'(out_unit), 32'(q[0].unit));
      checkValue({tag, ".event"}, 32'(out_event), 32'(q[0].evt));
    end
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    model_reset();
    #12;
    checkOutput("reset");
    checkValue("reset.unit", 32'(out_unit), 32'd0);
    checkValue("reset.event", 32'(out_event), 32'd0);
    rst = 1'b0;

    // single spike on unit 1
    applyStimulus(2'b10, 4'b1000, 1'b1, 2'b11, 1'b0);
    step("t1.capture");
    checkValue("t1.not_yet_valid", 32'(out_valid), 32'd0);
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    step("t1.push");
    checkValue("t1.valid", 32'(out_valid), 32'd1);
    checkValue("t1.unit", 32'(out_unit), 32'd1);
    checkValue("t1.event", 32'(out_event), 32'b10);
    step("t1.pop");
    checkValue("t1.empty", 32'(fifo_level), 32'd0);

    // simultaneous spikes, then unit 0 hogging
    applyStimulus(2'b11, 4'b1101, 1'b1, 2'b11, 1'b0);
    step("t2.capture");
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    step("t2.first");
    checkValue("t2.first_unit", 32'(out_unit), 32'd0);
    checkValue("t2.first_event", 32'(out_event), 32'b01);
    step("t2.second");
    checkValue("t2.second_unit", 32'(out_unit), 32'd1);
    checkValue("t2.second_event", 32'(out_event), 32'b11);
    step("t2.drain");
    applyStimulus(2'b11, 4'($urandom), 1'b1, 2'b11, 1'b0);
    step("t2.hog");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 4'($urandom), 1'b1, 2'b11, 1'b0);
      step("t2.hog");
    end
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) step("t2.tail");
    checkValue("t2.ovf_cleared", 32'(overflow), 32'd0);

    // saturation with the consumer stalled
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b10, 4'($urandom), 1'b0, 2'b11, 1'b0);
      step("t3.fill");
    end
    applyStimulus(2'b00, 4'b0000, 1'b0, 2'b11, 1'b0);
    step("t3.hold");
    checkValue("t3.full", 32'(fifo_level), 32'd4);
    checkValue("t3.no_drop_yet", 32'(overflow), 32'd0);
    applyStimulus(2'b01, 4'($urandom), 1'b0, 2'b11, 1'b0);
    step("t3.drop");
    checkValue("t3.overflow", 32'(overflow), 32'd1);
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) step("t3.drain");
    checkValue("t3.drained", 32'(fifo_level), 32'd0);

    // overflow set beats clear
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b1);
    step("t6.clr");
    checkValue("t6.clr_alone", 32'(overflow), 32'd0);
    applyStimulus(2'b11, 4'($urandom), 1'b1, 2'b11, 1'b0);
    step("t6.load");
    applyStimulus(2'b11, 4'($urandom), 1'b1, 2'b11, 1'b1);
    step("t6.drop_and_clr");
    checkValue("t6.set_wins", 32'(overflow), 32'd1);
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b1);
    step("t6.clr_again");
    checkValue("t6.cleared", 32'(overflow), 32'd0);
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) step("t6.drain");

    // masked unit
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b10, 4'($urandom), 1'b1, 2'b01, 1'b0);
      step("t4.masked");
    end
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b01, 1'b0);
    step("t4.idle");
    step("t4.idle");
    checkValue("t4.no_output", 32'(out_valid), 32'd0);
    checkValue("t4.no_overflow", 32'(overflow), 32'd0);
    applyStimulus(2'b10, 4'b1100, 1'b1, 2'b11, 1'b0);
    step("t4.capture");
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b01, 1'b0);
    step("t4.unmask");
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    step("t4.after");
    step("t4.after");
    checkValue("t4.discarded", 32'(out_valid), 32'd0);

    // asynchronous reset with a partly full queue
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b10, 4'($urandom), 1'b0, 2'b11, 1'b0);
      step("t5.fill");
    end
    applyStimulus(2'b00, 4'b0000, 1'b0, 2'b11, 1'b0);
    step("t5.settle");
    checkValue("t5.level3", 32'(fifo_level), 32'd3);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checkValue("t5.async_valid", 32'(out_valid), 32'd0);
    checkValue("t5.async_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    applyStimulus(2'b01, 4'b0011, 1'b1, 2'b11, 1'b0);
    step("t5.capture");
    applyStimulus(2'b00, 4'b0000, 1'b1, 2'b11, 1'b0);
    step("t5.push");
    checkValue("t5.post_valid", 32'(out_valid), 32'd1);
    checkValue("t5.post_unit", 32'(out_unit), 32'd0);
    checkValue("t5.post_event", 32'(out_event), 32'b11);
    step("t5.pop");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
                    ($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
